// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the MEM stage: memory op codes, data-memory width codes
// and slot FSM states.
package cpu_mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    localparam logic [1:0] WBH_NONE = 2'b00;
    localparam logic [1:0] WBH_WORD = 2'b01;
    localparam logic [1:0] WBH_HALF = 2'b10;
    localparam logic [1:0] WBH_BYTE = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } slot_state_e;

    typedef struct packed {
        mem_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        regwrite;
    } slot_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// EX-side, data-memory and WB-side signals of the MEM stage. The stage uses the
// slave view; the surrounding pipeline/memory uses the master view.
interface mem_access_stage_if #(
    parameter int AW = 13,
    parameter int RW = 5
) ();
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    ex_op;
    logic [31:0]   ex_addr;
    logic [31:0]   ex_wdata;
    logic [RW-1:0] ex_rd;
    logic          ex_regwrite;

    logic          dm_wena;
    logic [1:0]    dm_wbh;
    logic          dm_wbh_fh;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;

    logic          wb_valid;
    logic          wb_ready;
    logic [RW-1:0] wb_rd;
    logic          wb_regwrite;
    logic [31:0]   wb_data;
    logic          wb_exc;

    modport slave (
        input  ex_valid, ex_op, ex_addr, ex_wdata, ex_rd, ex_regwrite,
        output ex_ready,
        output dm_wena, dm_wbh, dm_wbh_fh, dm_addr, dm_wdata,
        input  dm_rdata,
        output wb_valid, wb_rd, wb_regwrite, wb_data, wb_exc,
        input  wb_ready
    );

    modport master (
        output ex_valid, ex_op, ex_addr, ex_wdata, ex_rd, ex_regwrite,
        input  ex_ready,
        input  dm_wena, dm_wbh, dm_wbh_fh, dm_addr, dm_wdata,
        output dm_rdata,
        input  wb_valid, wb_rd, wb_regwrite, wb_data, wb_exc,
        output wb_ready
    );
endinterface

// File: rtl/mem_op_decode.sv
// Combinational decode of a memory op into data-memory width/extension controls
// and the alignment check used by the trap option.
module mem_op_decode
    import cpu_mem_pkg::*;
(
    input  mem_op_e    op_i,
    input  logic [1:0] addr_lo_i,
    output logic [1:0] wbh_o,
    output logic       wbh_fh_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       misaligned_o
);

    always_comb begin
        wbh_o      = WBH_NONE;
        wbh_fh_o   = 1'b0;
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        case (op_i)
            OP_LW:   begin wbh_o = WBH_WORD; is_load_o = 1'b1; end
            OP_LH:   begin wbh_o = WBH_HALF; is_load_o = 1'b1; wbh_fh_o = 1'b1; end
            OP_LHU:  begin wbh_o = WBH_HALF; is_load_o = 1'b1; end
            OP_LB:   begin wbh_o = WBH_BYTE; is_load_o = 1'b1; wbh_fh_o = 1'b1; end
            OP_LBU:  begin wbh_o = WBH_BYTE; is_load_o = 1'b1; end
            OP_SW:   begin wbh_o = WBH_WORD; is_store_o = 1'b1; end
            OP_SH:   begin wbh_o = WBH_HALF; is_store_o = 1'b1; end
            OP_SB:   begin wbh_o = WBH_BYTE; is_store_o = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned_o = ((wbh_o == WBH_WORD) && (addr_lo_i != 2'b00)) ||
                          ((wbh_o == WBH_HALF) && addr_lo_i[0]);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one-deep slot that drives the data memory for a single
// cycle, then a WB result register. MISALIGN_TRAP_EN turns misaligned accesses into traps.
module mem_access_stage
    import cpu_mem_pkg::*;
#(
    parameter int AW = 13,
    parameter int RW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_stage_if.slave bus
);

    slot_state_e   state_q, state_d;
    slot_t         slot_q, slot_d;
    logic [RW-1:0] rd_q, rd_d;

    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic          wb_regwrite_q, wb_regwrite_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          wb_exc_q, wb_exc_d;

    logic [1:0]    wbh;
    logic          wbh_fh, is_load, is_store, misaligned, exc;
    logic          occupied, adv, ready, accept;
    logic [AW-1:0] addr_out;

    mem_op_decode u_dec (
        .op_i        (slot_q.op),
        .addr_lo_i   (slot_q.addr[1:0]),
        .wbh_o       (wbh),
        .wbh_fh_o    (wbh_fh),
        .is_load_o   (is_load),
        .is_store_o  (is_store),
        .misaligned_o(misaligned)
    );

`ifdef MISALIGN_TRAP_EN
    assign exc      = misaligned;
    assign addr_out = slot_q.addr[AW-1:0];
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign exc = 1'b0;
    // Without the trap, misaligned addresses silently snap to natural alignment.
    always_comb begin
        addr_out = slot_q.addr[AW-1:0];
        if (wbh == WBH_WORD)      addr_out[1:0] = 2'b00;
        else if (wbh == WBH_HALF) addr_out[0]   = 1'b0;
    end
`endif

    assign occupied = (state_q != ST_EMPTY);
    assign adv      = !wb_valid_q || bus.wb_ready;
    assign ready    = !occupied || adv;
    assign accept   = bus.ex_valid && ready;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        rd_d          = rd_q;
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_data_d     = wb_data_q;
        wb_exc_d      = wb_exc_q;

        case (state_q)
            ST_EMPTY:            if (bus.ex_valid) state_d = ST_ACCESS;
            ST_ACCESS, ST_HOLD:  state_d = !adv ? ST_HOLD :
                                           (bus.ex_valid ? ST_ACCESS : ST_EMPTY);
            default:             state_d = ST_EMPTY;
        endcase

        if (accept) begin
            slot_d = '{op: mem_op_e'(bus.ex_op), addr: bus.ex_addr,
                       wdata: bus.ex_wdata, regwrite: bus.ex_regwrite};
            rd_d   = bus.ex_rd;
        end

        // The WB register moves whenever it is free or being drained; it only
        // captures a new result when the slot actually holds an instruction.
        if (adv) begin
            wb_valid_d = occupied;
            if (occupied) begin
                wb_rd_d       = rd_q;
                wb_regwrite_d = slot_q.regwrite && !is_store && !exc;
                wb_data_d     = (is_load && !exc) ? bus.dm_rdata : slot_q.addr;
                wb_exc_d      = exc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            slot_q        <= '0;
            rd_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_data_q     <= '0;
            wb_exc_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            rd_q          <= rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_data_q     <= wb_data_d;
            wb_exc_q      <= wb_exc_d;
        end
    end

    // Write enable is gated by rst_n so an in-flight store dies the instant reset asserts.
    assign bus.dm_wena     = rst_n && (state_q == ST_ACCESS) && is_store && !exc;
    assign bus.dm_wbh      = occupied ? wbh : WBH_NONE;
    assign bus.dm_wbh_fh   = occupied && wbh_fh;
    assign bus.dm_addr     = addr_out;
    assign bus.dm_wdata    = slot_q.wdata;
    assign bus.ex_ready    = ready;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_regwrite = wb_regwrite_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_exc      = wb_exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a byte-lane memory that writes on negedge.
module tb_mem_access_stage;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_stage_if #(.AW(13), .RW(5)) bus ();
    mem_access_stage #(.AW(13), .RW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        exc;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0, errs = 0, wena_cnt = 0, cyc = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: little-endian bytes, combinational extended read.
    bit   [7:0]  mem [0:8191];
    logic [12:0] a0, a1, a2, a3;
    logic [15:0] hw;
    logic [7:0]  bt;
    always_comb begin
        a0 = bus.dm_addr;
        a1 = a0 + 13'd1;
        a2 = a0 + 13'd2;
        a3 = a0 + 13'd3;
        hw = {mem[a1], mem[a0]};
        bt = mem[a0];
        case (bus.dm_wbh)
            WBH_WORD: bus.dm_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
            WBH_HALF: bus.dm_rdata = bus.dm_wbh_fh ? {{16{hw[15]}}, hw} : {16'h0, hw};
            WBH_BYTE: bus.dm_rdata = bus.dm_wbh_fh ? {{24{bt[7]}}, bt} : {24'h0, bt};
            default:  bus.dm_rdata = 32'h0;
        endcase
    end

    always @(negedge clk) begin
        if (bus.dm_wena) begin
            mem[a0] <= bus.dm_wdata[7:0];
            if (bus.dm_wbh != WBH_BYTE) mem[a1] <= bus.dm_wdata[15:8];
            if (bus.dm_wbh == WBH_WORD) begin
                mem[a2] <= bus.dm_wdata[23:16];
                mem[a3] <= bus.dm_wdata[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rw,
                         input logic [31:0] edata, input logic erw, input logic eexc);
        int n;
        exp_t e;
        n = 0;
        bus.ex_valid = 1'b1; bus.ex_op = op; bus.ex_addr = addr;
        bus.ex_wdata = wdata; bus.ex_rd = rd; bus.ex_regwrite = rw;
        @(negedge clk);
        while (!bus.ex_ready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) begin
            vecs++; errs++;
            $display("FAIL accept_timeout: op %0d addr 0x%08h never accepted", op, addr);
        end else begin
            @(posedge clk); #1;
            e = '{rd: rd, rw: erw, data: edata, exc: eexc, acc: cyc, lat: lat_chk};
            exp_q.push_back(e);
        end
        bus.ex_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin n++; @(negedge clk); end
        if (exp_q.size() != 0) begin
            vecs++; errs++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every WB handshake and checks WB holds steady under backpressure.
    initial begin
        logic [39:0] cur, prev;
        bit have_prev;
        exp_t e;
        have_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) have_prev = 1'b0;
            else begin
                if (bus.dm_wena) wena_cnt++;
                cur = {bus.wb_valid, bus.wb_rd, bus.wb_regwrite, bus.wb_data, bus.wb_exc};
                if (have_prev) begin
                    vecs++;
                    if (cur !== prev) begin
                        errs++;
                        $display("FAIL wb_stable: got 0x%010h want 0x%010h", cur, prev);
                    end
                end
                if (bus.wb_valid && bus.wb_ready) begin
                    vecs++;
                    if (exp_q.size() == 0) begin
                        errs++;
                        $display("FAIL wb_unexpected: got rd %0d data 0x%08h, want nothing", bus.wb_rd, bus.wb_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.wb_rd !== e.rd || bus.wb_regwrite !== e.rw ||
                            bus.wb_data !== e.data || bus.wb_exc !== e.exc ||
                            (e.lat && cyc != e.acc + 1)) begin
                            errs++;
                            $display("FAIL wb_result: got rd %0d rw %0b data 0x%08h exc %0b cyc %0d, want rd %0d rw %0b data 0x%08h exc %0b cyc %0d",
                                     bus.wb_rd, bus.wb_regwrite, bus.wb_data, bus.wb_exc, cyc,
                                     e.rd, e.rw, e.data, e.exc, e.acc + 1);
                        end
                    end
                end
                have_prev = bus.wb_valid && !bus.wb_ready;
                prev = cur;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.ex_valid = 1'b0; bus.ex_op = '0; bus.ex_addr = '0; bus.ex_wdata = '0;
        bus.ex_rd = '0; bus.ex_regwrite = 1'b0; bus.wb_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
        chk("rst_wb_rd", {27'b0, bus.wb_rd}, 32'h0);
        chk("rst_wb_regwrite", {31'b0, bus.wb_regwrite}, 32'h0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_wb_exc", {31'b0, bus.wb_exc}, 32'h0);
        chk("rst_dm_wena", {31'b0, bus.dm_wena}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ex_ready", {31'b0, bus.ex_ready}, 32'h1);
        @(posedge clk); #1;

        // 1: SW then LW back-to-back, plus an address above AW that wraps
        wena_cnt = 0;
        issue(OP_SW, 32'h10, 32'hDEADBEEF, 5'd3, 1'b1, 32'h10, 1'b0, 1'b0);
        issue(OP_LW, 32'h10, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        issue(OP_LW, 32'h2010, 32'h0, 5'd6, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        drain();
        chk("t1_wena_pulses", wena_cnt, 32'd1);

        // 2: byte store, signed and unsigned byte loads
        issue(OP_SB, 32'h13, 32'h12345680, 5'd7, 1'b0, 32'h13, 1'b0, 1'b0);
        issue(OP_LB, 32'h13, 32'h0, 5'd8, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0);
        issue(OP_LBU, 32'h13, 32'h0, 5'd9, 1'b1, 32'h00000080, 1'b1, 1'b0);
        drain();

        // 3: WB backpressure holds a store in the slot
        lat_chk = 1'b0;
        bus.wb_ready = 1'b0;
        issue(OP_NONE, 32'h99, 32'h0, 5'd2, 1'b1, 32'h99, 1'b1, 1'b0);
        wena_cnt = 0;
        issue(OP_SW, 32'h40, 32'hCAFEF00D, 5'd1, 1'b1, 32'h40, 1'b0, 1'b0);
        bus.ex_valid = 1'b1; bus.ex_op = OP_LW; bus.ex_addr = 32'h40; bus.ex_rd = 5'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_ex_ready_hold", {31'b0, bus.ex_ready}, 32'h0);
            chk("t3_wb_data_hold", bus.wb_data, 32'h99);
        end
        #1 chk("t3_wena_pulses", wena_cnt, 32'd1);
        @(posedge clk); #1 bus.wb_ready = 1'b1;
        issue(OP_LW, 32'h40, 32'h0, 5'd10, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        drain();
        lat_chk = 1'b1;

        // 4: reset during the access cycle of a half store
        issue(OP_SH, 32'h30, 32'h00001234, 5'd0, 1'b0, 32'h30, 1'b0, 1'b0);
        drain();
        issue(OP_SH, 32'h30, 32'h0000BEEF, 5'd0, 1'b0, 32'h30, 1'b0, 1'b0);
        chk("t4_wena_before", {31'b0, bus.dm_wena}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_wena_in_reset", {31'b0, bus.dm_wena}, 32'h0);
        chk("t4_wb_valid_in_reset", {31'b0, bus.wb_valid}, 32'h0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(OP_LHU, 32'h30, 32'h0, 5'd11, 1'b1, 32'h00001234, 1'b1, 1'b0);
        drain();

        // 5: misaligned half load
        issue(OP_SH, 32'h20, 32'h00008001, 5'd0, 1'b0, 32'h20, 1'b0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        issue(OP_LH, 32'h21, 32'h0, 5'd12, 1'b1, 32'h21, 1'b0, 1'b1);
        chk("t5_dm_addr", {19'b0, bus.dm_addr}, 32'h21);
`else
        issue(OP_LH, 32'h21, 32'h0, 5'd12, 1'b1, 32'hFFFF8001, 1'b1, 1'b0);
        chk("t5_dm_addr", {19'b0, bus.dm_addr}, 32'h20);
`endif
        chk("t5_dm_wbh", {30'b0, bus.dm_wbh}, 32'h2);
        chk("t5_dm_wbh_fh", {31'b0, bus.dm_wbh_fh}, 32'h1);
        drain();

        // 6: eight stores then eight loads streamed at full rate
        for (int i = 0; i < 8; i++)
            issue(OP_SW, 32'h100 + 32'(4 * i), 32'h10000000 | 32'(i), 5'd0, 1'b0,
                  32'h100 + 32'(4 * i), 1'b0, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            issue(OP_LW, 32'h100 + 32'(4 * i), 32'h0, 5'(i + 1), 1'b1,
                  32'h10000000 | 32'(i), 1'b1, 1'b0);
        chk("t6_accept_cycles", cyc - c0, 32'd8);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
